instr_issue_ctrl: RTL and testbench
===================================

# instr_issue_ctrl

Sequencing front end between instruction fetch and the execute stage of the lab core. Accepts 32-bit instructions over a valid/ready handshake, decodes them through the shared `instruction_decoder`, registers the resulting control word, and issues it to execute over a second valid/ready handshake. Also tracks the last issued destination register to drive forwarding selects, halts on unsupported opcodes until flushed, and counts retired issues.

## Interface
- `CNT_W`, default 32: width of the issued-instruction counter.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush; clears the held instruction and the halt.
- `in_valid`  in  1  fetch presents `in_instr`.
- `in_ready`  out  1  controller accepts `in_instr` this cycle.
- `in_instr`  in  32  raw instruction word.
- `ex_valid`  out  1  issued control word valid.
- `ex_ready`  in  1  execute consumes the word this cycle.
- `ex_rd`, `ex_rs1`, `ex_rs2`  out  5 each  register fields.
- `ex_funct3`  out  3; `ex_funct7`  out  7: ALU operation select fields.
- `ex_imm`  out  32  operand immediate: I-type sign-extended, U-type `<<12`, shamt zero-extended for shifts.
- `ex_alu_src`  out  1  1 = immediate operand B.
- `ex_regsel`  out  2  writeback select: 00 ALU, 01 LUI immediate, 10 CSR read.
- `ex_we`  out  1  register write enable; forced 0 when rd = x0.
- `ex_csr_we`  out  1  CSR write (CSRRW).
- `ex_fwd_a`, `ex_fwd_b`  out  1 each  rs1/rs2 equals the rd of the previously issued writing instruction.
- `halted`  out  1  illegal instruction seen; issue stopped.
- `issue_cnt`  out  CNT_W  number of completed `ex_valid && ex_ready` handshakes.

## Operation
- Supported encodings: opcode 0110011 (R), 0010011 (I arithmetic/shift), 0110111 (LUI), 1110011 with funct3 = 001 (CSRRW). Everything else is illegal.
- States: RUN and HALT.
  - RUN: normal issue.
  - HALT: entered when an illegal instruction is accepted. The illegal word is not issued. `in_ready` = 0 and `halted` = 1. Exit only by `flush` or reset.
- Output stage is a single register holding the control word and `ex_valid`.
  - `in_ready` = (state == RUN) && (!ex_valid || ex_ready). This allows one instruction per cycle at full throughput.
  - On an input handshake with a legal instruction: load the control word and set `ex_valid`.
  - On an output handshake with no new legal input: clear `ex_valid`.
- Forwarding: registers `last_rd`/`last_we` update on every output handshake. `ex_fwd_a` = `last_we` && (rs1 == `last_rd`), computed when the word is loaded. `ex_fwd_b` is computed the same way from rs2. Both selects are 0 when the source register is x0.
- Shift-immediates (funct3 001/101 with opcode 0010011): `ex_imm` = {27'b0, shamt}; `ex_funct7` = instr[31:25].
- CSRRW: `ex_regsel` = 10, `ex_we` = (rd ≠ 0), `ex_csr_we` = 1, `ex_alu_src` = 0.
- `issue_cnt` increments by 1 per output handshake and wraps modulo 2^CNT_W.
- Priority: reset > flush > handshakes.
  - Flush clears `ex_valid` and `last_we` and returns the state to RUN.
  - Flush does not clear `issue_cnt`.
  - An input presented in the flush cycle is dropped (`in_ready` = 0 that cycle).

## Timing
- Reset values: state RUN, `ex_valid` 0, all `ex_*` fields 0, `last_we` 0, `halted` 0, `issue_cnt` 0. `in_ready` is 1 in the first cycle after reset.
- Latency: an instruction accepted at edge N appears on `ex_*` after edge N; the earliest issue handshake is at edge N+1.
- `ex_*` holds stable while `ex_valid && !ex_ready`; execute backpressure stalls fetch in the same cycle.
- `in_ready` is combinational from state, `ex_valid`, `ex_ready`, and `flush`. There is no combinational path from `in_valid` to `in_ready`.
- Illegal accepted at edge N: `halted` = 1 after edge N. A prior word still in the output register continues to drain normally.
- Simultaneous input and output handshake: the output register reloads; `last_rd` captures the outgoing word's rd before the new word's forwarding compare.
- Reset mid-stall discards the held word without an issue handshake.

## Structure
- `issue_pkg`: opcode constants (OP_R, OP_I, OP_LUI, OP_SYS), `state_t` enum {RUN, HALT}, `regsel_t` enum {SEL_ALU, SEL_LUI, SEL_CSR}, packed `ctrl_word_t` struct for the output register.
- Sub-module: one `instruction_decoder` instance for field and immediate extraction. Legality, control generation, FSM, forwarding and the counter live in `instr_issue_ctrl`.

## Test plan
- Reset, then stream `addi x1,x0,5` (0x00500093) and `add x2,x1,x1` (0x00108133) with `ex_ready`=1 → issued back-to-back; second word has `ex_fwd_a`=`ex_fwd_b`=1; `issue_cnt`=2.
- `lui x3,0x12345` (0x123451B7) → `ex_imm`=0x12345000, `ex_regsel`=01, `ex_we`=1; `slli x4,x3,7` → `ex_imm`=7, `ex_alu_src`=1.
- Hold `ex_ready`=0 for 4 cycles with a word held → `in_ready`=0, `ex_*` unchanged, `issue_cnt` unchanged until release.
- Send 0x00000000 (illegal) after a pending `addi` → `addi` issues, `halted`=1, `in_ready`=0; assert `flush` for 1 cycle → `halted`=0, `in_ready`=1, next word gets `ex_fwd_*`=0.
- `csrrw x0,0x782,x5` → `ex_csr_we`=1, `ex_we`=0; a following `add x6,x0,x0` → `ex_fwd_a`=`ex_fwd_b`=0.
- With `CNT_W`=4, issue 17 instructions → `issue_cnt`=1 (wrap).

Source files
------------

// File: rtl/instr_issue_ctrl_pkg.sv
// Shared types and encodings for the instruction issue front end.
// Opcode constants, FSM state, writeback selects and the registered control word.
package issue_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SYS = 7'b1110011;

    localparam logic [2:0] F3_CSRRW = 3'b001;
    localparam logic [2:0] F3_SLLI  = 3'b001;
    localparam logic [2:0] F3_SRXI  = 3'b101;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SEL_ALU = 2'b00,
        SEL_LUI = 2'b01,
        SEL_CSR = 2'b10
    } regsel_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        alu_src;
        regsel_t     regsel;
        logic        we;
        logic        csr_we;
        logic        fwd_a;
        logic        fwd_b;
    } ctrl_word_t;

    // Shift-immediates carry a zero-extended shamt instead of a signed immediate.
    function automatic logic is_shift_imm(input logic [2:0] funct3);
        return (funct3 == F3_SLLI) || (funct3 == F3_SRXI);
    endfunction

endpackage

// File: rtl/instr_issue_ctrl_decoder.sv
// Field and immediate extraction for a raw 32-bit instruction word.
// Purely combinational; legality and control generation live in the issue controller.
module instruction_decoder (
    input  logic [31:0] instr_i,
    output logic [6:0]  opcode_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [31:0] imm_i_o,
    output logic [31:0] imm_u_o,
    output logic [4:0]  shamt_o
);

    always_comb begin
        opcode_o = instr_i[6:0];
        rd_o     = instr_i[11:7];
        funct3_o = instr_i[14:12];
        rs1_o    = instr_i[19:15];
        rs2_o    = instr_i[24:20];
        funct7_o = instr_i[31:25];
        imm_i_o  = {{20{instr_i[31]}}, instr_i[31:20]};
        imm_u_o  = {instr_i[31:12], 12'b0};
        shamt_o  = instr_i[24:20];
    end

endmodule

// File: rtl/instr_issue_ctrl.sv
// Issue controller between fetch and execute: decode, register the control word,
// issue over valid/ready, track the last writer for forwarding, halt on illegal opcodes.
import issue_pkg::*;

module instr_issue_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [4:0]       ex_rd,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [2:0]       ex_funct3,
    output logic [6:0]       ex_funct7,
    output logic [31:0]      ex_imm,
    output logic             ex_alu_src,
    output logic [1:0]       ex_regsel,
    output logic             ex_we,
    output logic             ex_csr_we,
    output logic             ex_fwd_a,
    output logic             ex_fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] issue_cnt
);

    state_t           state_q;
    logic             ex_valid_q;
    ctrl_word_t       ex_q;
    ctrl_word_t       word_d;
    logic [4:0]       last_rd_q;
    logic             last_we_q;
    logic [CNT_W-1:0] cnt_q;

    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [2:0]  dec_funct3;
    logic [6:0]  dec_funct7;
    logic [31:0] dec_imm_i;
    logic [31:0] dec_imm_u;
    logic [4:0]  dec_shamt;

    logic       legal;
    logic       in_hs;
    logic       out_hs;
    logic [4:0] fwd_rd;
    logic       fwd_we;

    instruction_decoder u_dec (
        .instr_i  (in_instr),
        .opcode_o (dec_opcode),
        .rd_o     (dec_rd),
        .rs1_o    (dec_rs1),
        .rs2_o    (dec_rs2),
        .funct3_o (dec_funct3),
        .funct7_o (dec_funct7),
        .imm_i_o  (dec_imm_i),
        .imm_u_o  (dec_imm_u),
        .shamt_o  (dec_shamt)
    );

    assign in_ready = (state_q == RUN) && (!ex_valid_q || ex_ready) && !flush;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = ex_valid_q && ex_ready;

    always_comb begin
        word_d        = '0;
        legal         = 1'b0;
        word_d.rd     = dec_rd;
        word_d.rs1    = dec_rs1;
        word_d.rs2    = dec_rs2;
        word_d.funct3 = dec_funct3;
        word_d.funct7 = dec_funct7;
        word_d.regsel = SEL_ALU;
        case (dec_opcode)
            OP_R: begin
                legal     = 1'b1;
                word_d.we = (dec_rd != 5'd0);
            end
            OP_I: begin
                legal          = 1'b1;
                word_d.alu_src = 1'b1;
                word_d.we      = (dec_rd != 5'd0);
                word_d.imm     = is_shift_imm(dec_funct3) ? {27'b0, dec_shamt} : dec_imm_i;
            end
            OP_LUI: begin
                legal          = 1'b1;
                word_d.alu_src = 1'b1;
                word_d.regsel  = SEL_LUI;
                word_d.we      = (dec_rd != 5'd0);
                word_d.imm     = dec_imm_u;
            end
            OP_SYS: begin
                if (dec_funct3 == F3_CSRRW) begin
                    legal         = 1'b1;
                    word_d.regsel = SEL_CSR;
                    word_d.we     = (dec_rd != 5'd0);
                    word_d.csr_we = 1'b1;
                    word_d.imm    = dec_imm_i;
                end
            end
            default: ;
        endcase

        // When the held word leaves in this same cycle it is the most recent writer,
        // so compare against it rather than the not-yet-updated last_rd_q.
        fwd_rd       = out_hs ? ex_q.rd : last_rd_q;
        fwd_we       = out_hs ? ex_q.we : last_we_q;
        word_d.fwd_a = fwd_we && (dec_rs1 != 5'd0) && (dec_rs1 == fwd_rd);
        word_d.fwd_b = fwd_we && (dec_rs2 != 5'd0) && (dec_rs2 == fwd_rd);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            ex_valid_q <= 1'b0;
            ex_q       <= '0;
            last_rd_q  <= '0;
            last_we_q  <= 1'b0;
            cnt_q      <= '0;
        end else if (flush) begin
            state_q    <= RUN;
            ex_valid_q <= 1'b0;
            last_we_q  <= 1'b0;
        end else begin
            if (out_hs) begin
                last_rd_q <= ex_q.rd;
                last_we_q <= ex_q.we;
                cnt_q     <= cnt_q + CNT_W'(1);
            end
            if (in_hs && legal) begin
                ex_q       <= word_d;
                ex_valid_q <= 1'b1;
            end else if (out_hs) begin
                ex_valid_q <= 1'b0;
            end
            if (in_hs && !legal) begin
                state_q <= HALT;
            end
        end
    end

    always_comb begin
        ex_valid   = ex_valid_q;
        ex_rd      = ex_q.rd;
        ex_rs1     = ex_q.rs1;
        ex_rs2     = ex_q.rs2;
        ex_funct3  = ex_q.funct3;
        ex_funct7  = ex_q.funct7;
        ex_imm     = ex_q.imm;
        ex_alu_src = ex_q.alu_src;
        ex_regsel  = ex_q.regsel;
        ex_we      = ex_q.we;
        ex_csr_we  = ex_q.csr_we;
        ex_fwd_a   = ex_q.fwd_a;
        ex_fwd_b   = ex_q.fwd_b;
        halted     = (state_q == HALT);
        issue_cnt  = cnt_q;
    end

endmodule

// File: tb/tb_instr_issue_ctrl.sv
// Scoreboard bench for instr_issue_ctrl: a driver pushes expected control words
// from a behavioural decode model, a negedge monitor pops and compares on each issue.
module tb_instr_issue_ctrl;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        alu_src;
        logic [1:0]  regsel;
        logic        we;
        logic        csr_we;
        logic        fwd_a;
        logic        fwd_b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic [31:0] ex_imm;
    logic        ex_alu_src;
    logic [1:0]  ex_regsel;
    logic        ex_we, ex_csr_we, ex_fwd_a, ex_fwd_b, halted;
    logic [3:0]  issue_cnt;
    logic [63:0] dut_word;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    int   cnt_m = 0;
    bit   halt_m = 0;
    bit   pwe = 0;
    logic [4:0] prd = '0;
    int   ready_mode = 0;
    bit   stall_prev = 0;
    logic [63:0] prev_word = '0;

    instr_issue_ctrl #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_imm(ex_imm),
        .ex_alu_src(ex_alu_src), .ex_regsel(ex_regsel), .ex_we(ex_we),
        .ex_csr_we(ex_csr_we), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .halted(halted), .issue_cnt(issue_cnt)
    );

    assign dut_word = {ex_rd, ex_rs1, ex_rs2, ex_funct3, ex_funct7, ex_imm,
                       ex_alu_src, ex_regsel, ex_we, ex_csr_we, ex_fwd_a, ex_fwd_b};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference decode written from the ISA rules, not the RTL structure.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [4:0] p_rd,
                                        input bit p_we, output bit legal);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        op = w[6:0];
        f3 = w[14:12];
        e = '0;
        legal = (op == 7'h33) || (op == 7'h13) || (op == 7'h37) || (op == 7'h73 && f3 == 3'd1);
        e.rd = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.f3 = f3;
        e.f7 = w[31:25];
        if (op == 7'h13) e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 32'(w[24:20]) : 32'($signed(w) >>> 20);
        else if (op == 7'h37) e.imm = w & 32'hFFFF_F000;
        else if (op == 7'h73) e.imm = 32'($signed(w) >>> 20);
        e.alu_src = (op == 7'h13) || (op == 7'h37);
        e.regsel = (op == 7'h37) ? 2'd1 : (op == 7'h73) ? 2'd2 : 2'd0;
        e.we = (e.rd != 0);
        e.csr_we = (op == 7'h73);
        e.fwd_a = p_we && e.rs1 != 0 && e.rs1 == p_rd;
        e.fwd_b = p_we && e.rs2 != 0 && e.rs2 == p_rd;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr(input bit allow_illegal);
        int unsigned k;
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [11:0] i12;
        logic [19:0] u20;
        k   = $urandom_range(0, allow_illegal ? 11 : 9);
        rd  = 5'($urandom_range(0, 3));
        rs1 = 5'($urandom_range(0, 3));
        rs2 = 5'($urandom_range(0, 3));
        f3  = 3'($urandom_range(0, 7));
        f7  = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        i12 = 12'($urandom);
        u20 = 20'($urandom);
        case (k)
            0, 1, 2: return {f7, rs2, rs1, f3, rd, 7'h33};
            3, 4:    return {i12, rs1, (f3 == 3'd1 || f3 == 3'd5) ? 3'd0 : f3, rd, 7'h13};
            5, 6:    return {f7, 5'($urandom), rs1, $urandom_range(0, 1) ? 3'd1 : 3'd5, rd, 7'h13};
            7, 8:    return {u20, rd, 7'h37};
            9:       return {i12, rs1, 3'd1, rd, 7'h73};
            10:      return {i12, rs1, 3'd2, rd, 7'h73};
            default: return {i12, rs1, f3, rd, 7'h03};
        endcase
    endfunction

    task automatic send(input logic [31:0] w);
        bit acc;
        bit lg;
        exp_t e;
        acc = 0;
        in_instr = w;
        in_valid = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready && !flush;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", 64'(acc), 64'd1);
            return;
        end
        e = ref_decode(w, prd, pwe, lg);
        if (lg) begin
            exp_q.push_back(e);
            prd = e.rd;
            pwe = e.we;
        end else begin
            halt_m = 1;
        end
    endtask

    task automatic drain_flush(input bit with_input);
        for (int i = 0; i < 64 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        flush = 1'b1;
        if (with_input) begin
            in_valid = 1'b1;
            in_instr = rand_instr(0);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        halt_m = 0;
        pwe = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.delete();
        cnt_m = 0;
        halt_m = 0;
        pwe = 0;
        prd = '0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_fields", dut_word, 64'd0);
        chk("reset_cnt", 64'(issue_cnt), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       ex_ready = 1'b0;
                2:       ex_ready = 1'b1;
                default: ex_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    always @(negedge clk) begin
        bit busy;
        if (rst_n) begin
            busy = (exp_q.size() != 0);
            chk("ex_valid", 64'(ex_valid), 64'(busy));
            chk("in_ready", 64'(in_ready), 64'(!halt_m && !flush && (!busy || ex_ready)));
            chk("halted", 64'(halted), 64'(halt_m));
            chk("issue_cnt", 64'(issue_cnt), 64'(cnt_m % 16));
            if (stall_prev) chk("stall_hold", dut_word, prev_word);
            if (busy && ex_ready && !flush) begin
                chk("issue_word", dut_word, 64'(exp_q[0]));
                void'(exp_q.pop_front());
                cnt_m++;
            end
            stall_prev = busy && !ex_ready && !flush;
            prev_word = dut_word;
        end else begin
            stall_prev = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        exp_t dummy;
        bit lg;
        do_reset();

        ready_mode = 2;
        send(32'h00500093);
        send(32'h00108133);
        @(posedge clk);
        #1;
        chk("cnt_after_two", 64'(issue_cnt), 64'd2);

        send(32'h123451B7);
        send(32'h00719213);

        ready_mode = 1;
        send(32'h00100293);
        fork
            send(32'h00528333);
            begin
                repeat (5) @(negedge clk);
                ready_mode = 0;
            end
        join

        ready_mode = 2;
        send(32'h00500093);
        send(32'h00000000);
        drain_flush(1);
        send(32'h001083B3);

        send(32'h78229073);
        send(32'h00000333);

        ready_mode = 0;
        for (int n = 0; n < 200; n++) begin
            w = rand_instr(1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(w);
            dummy = ref_decode(w, 5'd0, 0, lg);
            if (!lg) drain_flush($urandom_range(0, 1));
        end
        drain_flush(0);

        ready_mode = 1;
        send(32'h00100293);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        ready_mode = 2;
        send(32'h00528333);
        drain_flush(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
